// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture
//
// Camera-side capture stage. Samples the OV7670 byte stream (VSYNC/HREF/D)
// on the camera pixel clock, pairs consecutive bytes into RGB565 pixels,
// crops the sensor frame to the LCD window and pushes 17-bit words into the
// camera FIFO write port. Each captured frame is preceded by a marker word
// (bit 16 set). A write refused because the FIFO is full drops the rest of
// that frame; the next frame resynchronises through its own marker.
//
// Ports
//   clk           camera pixel clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   mem_ready     PSRAM calibration complete; only looked at after reset
//   cam_vsync     camera VSYNC, high = vertical blanking
//   cam_href      camera HREF, high = valid byte on cam_data
//   cam_data      camera byte, high byte of each pixel first
//   queue_full    FIFO full flag, evaluated at the edge issuing a write
//   queue_data    FIFO word: bit16 = frame marker, [15:0] = RGB565
//   queue_wr_en   FIFO write enable, one word per cycle
//   frame_done    one-cycle pulse when a frame has been captured completely
//   frame_count   number of captured frames, wraps 255 -> 0
//   overflow      sticky: a write was refused because of queue_full
//   format_error  sticky: a captured frame ended with a wrong line count

module ov7670_pixel_capture #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int OUT_WIDTH    = 480,
    parameter int OUT_HEIGHT   = 272,
    parameter int X_OFFSET     = 80,
    parameter int Y_OFFSET     = 104
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ready,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        queue_full,
    output logic [16:0] queue_data,
    output logic        queue_wr_en,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic        overflow,
    output logic        format_error
);

    typedef enum logic [2:0] {
        WAIT_READY,
        WAIT_BLANK,
        WAIT_FRAME,
        CAPTURE,
        DROP
    } state_t;

    // The crop window never reaches past the sensor edge, so a window
    // configured larger than the frame is clipped to it.
    localparam int X_END = (X_OFFSET + OUT_WIDTH < FRAME_WIDTH) ?
                           (X_OFFSET + OUT_WIDTH) : FRAME_WIDTH;
    localparam int Y_END = (Y_OFFSET + OUT_HEIGHT < FRAME_HEIGHT) ?
                           (Y_OFFSET + OUT_HEIGHT) : FRAME_HEIGHT;

    // Bounds are one bit wider than the counters so an end bound of 1024
    // still compares correctly against a saturated counter.
    localparam logic [10:0] X_LO   = 11'(X_OFFSET);
    localparam logic [10:0] X_HI   = 11'(X_END);
    localparam logic [10:0] Y_LO   = 11'(Y_OFFSET);
    localparam logic [10:0] Y_HI   = 11'(Y_END);
    localparam logic [9:0]  LINES  = 10'(FRAME_HEIGHT);
    localparam logic [16:0] MARKER = 17'h10000;

    state_t      state;
    state_t      state_nxt;

    logic [9:0]  x;
    logic [9:0]  y;
    logic        phase;
    logic        href_p1;
    logic [7:0]  hi_p1;

    logic        in_window;
    logic        marker_try;
    logic        pixel_evt;
    logic        line_end;
    logic        frame_end;
    logic        write_try;
    logic        do_write;
    logic        refuse;
    logic        hi_load;
    logic [16:0] word;

    // Counters stop at their maximum instead of wrapping, so an overlong
    // line or frame can never alias back into the crop window.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic in_range(input logic [9:0] v,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
        return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
    endfunction

    assign in_window = in_range(x, X_LO, X_HI) && in_range(y, Y_LO, Y_HI);

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_READY;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_READY: if (mem_ready) state_nxt = WAIT_BLANK;
            // Start only after seeing blanking, so the first captured
            // frame is always a whole one.
            WAIT_BLANK: if (cam_vsync) state_nxt = WAIT_FRAME;
            WAIT_FRAME: begin
                if (!cam_vsync) state_nxt = refuse ? DROP : CAPTURE;
            end
            CAPTURE: begin
                if (cam_vsync)   state_nxt = WAIT_FRAME;
                else if (refuse) state_nxt = DROP;
            end
            DROP:       if (cam_vsync) state_nxt = WAIT_FRAME;
            default:    state_nxt = WAIT_READY;
        endcase
    end

    // ---- per-cycle event decode ----
    // VSYNC has priority over HREF inside CAPTURE: a byte arriving on the
    // same edge as the blanking rise is ignored.
    always_comb begin
        marker_try = 1'b0;
        pixel_evt  = 1'b0;
        line_end   = 1'b0;
        frame_end  = 1'b0;
        hi_load    = 1'b0;
        case (state)
            WAIT_FRAME: marker_try = !cam_vsync;
            CAPTURE: begin
                if (cam_vsync) begin
                    frame_end = 1'b1;
                end else if (cam_href) begin
                    hi_load   = !phase;
                    pixel_evt = phase;
                end else if (href_p1) begin
                    line_end = 1'b1;
                end
            end
            default: ;
        endcase

        write_try = marker_try || (pixel_evt && in_window);
        do_write  = write_try && !queue_full;
        refuse    = write_try && queue_full;
        word      = marker_try ? MARKER : {1'b0, hi_p1, cam_data};
    end

    // ---- registered outputs and counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queue_data   <= 17'h0;
            queue_wr_en  <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= 8'd0;
            overflow     <= 1'b0;
            format_error <= 1'b0;
            x            <= 10'd0;
            y            <= 10'd0;
            phase        <= 1'b0;
            href_p1      <= 1'b0;
        end else begin
            href_p1     <= cam_href;
            queue_wr_en <= do_write;
            frame_done  <= frame_end;

            if (do_write) begin
                queue_data <= word;
            end

            if (refuse) begin
                overflow <= 1'b1;
            end

            if (frame_end) begin
                frame_count <= frame_count + 8'd1;
                if (y != LINES) begin
                    format_error <= 1'b1;
                end
            end

            // x/y are indices of the pixel being completed, so x advances
            // after the window test of the current low byte.
            if (marker_try) begin
                x     <= 10'd0;
                y     <= 10'd0;
                phase <= 1'b0;
            end else if (hi_load) begin
                phase <= 1'b1;
            end else if (pixel_evt) begin
                phase <= 1'b0;
                x     <= sat_inc(x);
            end else if (line_end) begin
                // A half pixel left at the end of a line is discarded here.
                phase <= 1'b0;
                x     <= 10'd0;
                y     <= sat_inc(y);
            end
        end
    end

    // ---- high-byte holding register (pure data, no reset needed) ----
    always_ff @(posedge clk) begin
        if (hi_load) begin
            hi_p1 <= cam_data;
        end
    end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Testbench for ov7670_pixel_capture using a small 8x4 sensor and a 4x2
// crop window at (2,1). Expected FIFO words and frame-done events are
// computed per frame from the image arrays and pushed into queues; a
// monitor pops and compares whenever the DUT writes or pulses frame_done.

module tb_ov7670_pixel_capture;

    localparam int FW = 8;
    localparam int FH = 4;
    localparam int OW = 4;
    localparam int OH = 2;
    localparam int XO = 2;
    localparam int YO = 1;

    logic        clk;
    logic        rst_n;
    logic        mem_ready;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        queue_full;
    logic [16:0] queue_data;
    logic        queue_wr_en;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        overflow;
    logic        format_error;

    int checks = 0;
    int errors = 0;

    logic [16:0] expq  [$];
    logic [8:0]  doneq [$];

    logic [7:0]  img_hi [0:7][0:15];
    logic [7:0]  img_lo [0:7][0:15];

    logic [7:0]  exp_cnt;
    logic        exp_ovf;
    logic        exp_fmt;

    logic [16:0] mon_w;
    logic [8:0]  mon_d;

    ov7670_pixel_capture #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .OUT_WIDTH   (OW),
        .OUT_HEIGHT  (OH),
        .X_OFFSET    (XO),
        .Y_OFFSET    (YO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_ready   (mem_ready),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .queue_full  (queue_full),
        .queue_data  (queue_data),
        .queue_wr_en (queue_wr_en),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .overflow    (overflow),
        .format_error(format_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (queue_wr_en) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected got %05h required no write", queue_data);
                end else begin
                    mon_w = expq.pop_front();
                    if (queue_data !== mon_w) begin
                        errors++;
                        $display("FAIL write_data got %05h required %05h", queue_data, mon_w);
                    end
                end
            end
            if (frame_done) begin
                checks++;
                if (doneq.size() == 0) begin
                    errors++;
                    $display("FAIL frame_done_unexpected count %0d", frame_count);
                end else begin
                    mon_d = doneq.pop_front();
                    if ({format_error, frame_count} !== mon_d) begin
                        errors++;
                        $display("FAIL frame_done_status got fmt=%0b cnt=%0d required fmt=%0b cnt=%0d",
                                 format_error, frame_count, mon_d[8], mon_d[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    task automatic check_empty(input string name);
        check({name, "_words_left"}, 32'(expq.size()), 32'd0);
        check({name, "_frames_left"}, 32'(doneq.size()), 32'd0);
        expq.delete();
        doneq.delete();
    endtask

    function automatic logic rbit();
        logic r;
        r = ($urandom_range(0, 1) == 1);
        return r;
    endfunction

    function automatic logic in_window(input int y, input int p);
        return (p >= XO) && (p < XO + OW) && (p < FW) &&
               (y >= YO) && (y < YO + OH) && (y < FH);
    endfunction

    // One call = one clock: inputs are applied and sampled at the next edge.
    task automatic drive(input logic vs, input logic hr, input logic [7:0] d, input logic full);
        cam_vsync  = vs;
        cam_href   = hr;
        cam_data   = d;
        queue_full = full;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pattern();
        for (int y = 0; y < 8; y++)
            for (int p = 0; p < 16; p++) begin
                img_hi[y][p] = 8'hA0 + 8'(2 * p);
                img_lo[y][p] = 8'(16 * y + p);
            end
    endtask

    task automatic fill_random();
        for (int y = 0; y < 8; y++)
            for (int p = 0; p < 16; p++) begin
                img_hi[y][p] = 8'($urandom);
                img_lo[y][p] = 8'($urandom);
            end
    endtask

    // Reference: marker, then every cropped pixel in raster order until the
    // first refused write; a frame that was not dropped reports done.
    task automatic model_frame(input int nl, input int np, input int fy, input int fx,
                               input logic mfull);
        logic dropped;
        dropped = 1'b0;
        if (mfull) begin
            exp_ovf = 1'b1;
            return;
        end
        expq.push_back(17'h10000);
        for (int y = 0; y < nl; y++)
            for (int p = 0; p < np; p++)
                if (!dropped && in_window(y, p)) begin
                    if (y == fy && p == fx) begin
                        exp_ovf = 1'b1;
                        dropped = 1'b1;
                    end else begin
                        expq.push_back({1'b0, img_hi[y][p], img_lo[y][p]});
                    end
                end
        if (!dropped) begin
            exp_cnt = exp_cnt + 8'd1;
            if (nl != FH) exp_fmt = 1'b1;
            doneq.push_back({exp_fmt, exp_cnt});
        end
    endtask

    // queue_full is asserted at (fy,fx)'s low byte; elsewhere it is random
    // only on cycles where no write can happen.
    task automatic run_frame(input int nl, input int np, input int fy, input int fx,
                             input logic mfull, input logic dangle, input logic modeled);
        if (modeled) model_frame(nl, np, fy, fx, mfull);
        drive(1'b1, 1'b0, 8'h00, rbit());
        drive(1'b1, 1'b0, 8'h00, rbit());
        drive(1'b0, 1'b0, 8'h00, mfull);
        repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, 8'h00, rbit());
        for (int y = 0; y < nl; y++) begin
            for (int p = 0; p < np; p++) begin
                drive(1'b0, 1'b1, img_hi[y][p], rbit());
                drive(1'b0, 1'b1, img_lo[y][p],
                      (y == fy && p == fx) ? 1'b1 : (in_window(y, p) ? 1'b0 : rbit()));
            end
            if (dangle) drive(1'b0, 1'b1, 8'h5A, rbit());
            repeat ($urandom_range(2, 4)) drive(1'b0, 1'b0, 8'h00, rbit());
        end
        drive(1'b1, 1'b0, 8'h00, rbit());
        drive(1'b1, 1'b0, 8'h00, rbit());
        if (modeled) begin
            check("overflow", 32'(overflow), 32'(exp_ovf));
            check("format_error", 32'(format_error), 32'(exp_fmt));
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        mem_ready  = 1'b0;
        cam_vsync  = 1'b0;
        cam_href   = 1'b0;
        cam_data   = 8'h00;
        queue_full = 1'b0;
        exp_cnt    = 8'd0;
        exp_ovf    = 1'b0;
        exp_fmt    = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_queue_data", 32'(queue_data), 32'h0);
        check("rst_wr_en", 32'(queue_wr_en), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_frame_count", 32'(frame_count), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_format_error", 32'(format_error), 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Memory not ready: whole frames go by without a single write.
        fill_pattern();
        run_frame(4, 8, -1, -1, 1'b0, 1'b0, 1'b0);
        run_frame(4, 8, -1, -1, 1'b0, 1'b0, 1'b0);
        check_empty("not_ready");

        // Known pattern frame: marker plus the 4x2 window.
        mem_ready = 1'b1;
        run_frame(4, 8, -1, -1, 1'b0, 1'b0, 1'b1);
        check("pattern_count", 32'(frame_count), 32'd1);
        check_empty("pattern");

        // FIFO full on the third window pixel drops the rest of the frame.
        run_frame(4, 8, 1, 4, 1'b0, 1'b0, 1'b1);
        check("drop_count", 32'(frame_count), 32'd1);
        run_frame(4, 8, -1, -1, 1'b0, 1'b0, 1'b1);
        check("recover_count", 32'(frame_count), 32'd2);
        check_empty("overflow");

        // Short frame with a dangling byte at the end of every line.
        run_frame(3, 8, -1, -1, 1'b0, 1'b1, 1'b1);
        check_empty("short_frame");

        // FIFO full exactly at the marker edge drops that frame.
        fill_random();
        run_frame(4, 8, -1, -1, 1'b1, 1'b0, 1'b1);
        run_frame(4, 8, -1, -1, 1'b0, 1'b0, 1'b1);
        check_empty("marker_full");

        // Randomised frames: sizes, data, dangling bytes and full events.
        for (int f = 0; f < 24; f++) begin
            int fy;
            int fx;
            fill_random();
            fy = -1;
            fx = -1;
            if ($urandom_range(0, 3) == 0) begin
                fy = $urandom_range(0, 4);
                fx = $urandom_range(0, 8);
            end
            run_frame($urandom_range(3, 5), $urandom_range(6, 9), fy, fx,
                      ($urandom_range(0, 9) == 0), rbit(), 1'b1);
        end
        check_empty("random");

        // Reset mid-line: outputs clear at once, and nothing is written
        // until a full blanking period has been seen again.
        fill_random();
        expq.push_back(17'h10000);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int p = 0; p < 3; p++) begin
            drive(1'b0, 1'b1, img_hi[0][p], 1'b0);
            drive(1'b0, 1'b1, img_lo[0][p], 1'b0);
        end
        drive(1'b0, 1'b1, img_hi[0][3], 1'b0);
        check_empty("pre_reset");
        #2 rst_n = 1'b0;
        #1;
        check("midrst_queue_data", 32'(queue_data), 32'h0);
        check("midrst_wr_en", 32'(queue_wr_en), 32'h0);
        check("midrst_frame_done", 32'(frame_done), 32'h0);
        check("midrst_frame_count", 32'(frame_count), 32'h0);
        check("midrst_overflow", 32'(overflow), 32'h0);
        check("midrst_format_error", 32'(format_error), 32'h0);
        exp_cnt = 8'd0;
        exp_ovf = 1'b0;
        exp_fmt = 1'b0;
        drive(1'b0, 1'b1, img_lo[0][3], 1'b0);
        drive(1'b0, 1'b1, img_hi[0][4], 1'b0);
        #2 rst_n = 1'b1;
        drive(1'b0, 1'b1, img_lo[0][4], 1'b0);
        for (int p = 5; p < 8; p++) begin
            drive(1'b0, 1'b1, img_hi[0][p], 1'b0);
            drive(1'b0, 1'b1, img_lo[0][p], 1'b0);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int y = 1; y < 4; y++) begin
            for (int p = 0; p < 8; p++) begin
                drive(1'b0, 1'b1, img_hi[y][p], 1'b0);
                drive(1'b0, 1'b1, img_lo[y][p], 1'b0);
            end
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            drive(1'b0, 1'b0, 8'h00, 1'b0);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        check_empty("post_reset");
        check("post_reset_overflow", 32'(overflow), 32'h0);
        run_frame(4, 8, -1, -1, 1'b0, 1'b0, 1'b1);
        check("resync_count", 32'(frame_count), 32'd1);

        // Frame counter wraps after 256 captured frames.
        for (int f = 0; f < 255; f++) begin
            fill_random();
            run_frame(4, 8, -1, -1, 1'b0, 1'b0, 1'b1);
        end
        check("wrap_count", 32'(frame_count), 32'd0);
        check_empty("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
